axi_slave_write: RTL and testbench

- AXI4 write-channel responder; the far end of the team's AXI write master.
- Accepts one AW burst at a time (FIXED/INCR/WRAP, narrow or full width) and consumes the W beats.
- Drives a word-addressed memory write port with byte strobes, then returns one B response per burst.
- Used as a memory model / register-bank front end for bench and SoC bring-up.

---
 rtl/axi_slave_write.sv | 152 +++++++++++++++
 tb/tb_axi_slave_write.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_write.sv
// AXI4 write-channel responder: accepts one AW burst, writes its W beats to a
// word-addressed memory port with masked strobes, then returns a single B.
module axi_slave_write #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = DATA_WD / 8,
  parameter int MEM_AW  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               S_AXI_AWVALID,
  input  logic [ADDR_WD-1:0] S_AXI_AWADDR,
  input  logic [7:0]         S_AXI_AWLEN,
  input  logic [2:0]         S_AXI_AWSIZE,
  input  logic [1:0]         S_AXI_AWBURST,
  output logic               S_AXI_AWREADY,
  input  logic               S_AXI_WVALID,
  input  logic [DATA_WD-1:0] S_AXI_WDATA,
  input  logic [STRB_WD-1:0] S_AXI_WSTRB,
  input  logic               S_AXI_WLAST,
  output logic               S_AXI_WREADY,
  output logic               S_AXI_BVALID,
  output logic [1:0]         S_AXI_BRESP,
  input  logic               S_AXI_BREADY,
  output logic               mem_we,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [DATA_WD-1:0] mem_wdata,
  output logic [STRB_WD-1:0] mem_wstrb
);

  localparam int ADDRLSB = $clog2(STRB_WD);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  typedef enum logic [1:0] {B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10} burst_t;

  state_t             state;
  logic [ADDR_WD-1:0] addr;
  logic [ADDR_WD-1:0] wrap_base;
  logic [ADDR_WD-1:0] wrap_size;
  logic [2:0]         size;
  logic [1:0]         burst;
  logic [7:0]         cnt;
  logic               err;
  logic               no_write;

  logic [ADDR_WD-1:0] beat_bytes, size_mask, incr_addr, next_addr, aw_bound;
  logic [ADDRLSB-1:0] lane_lo, lane_hi;
  logic [STRB_WD-1:0] lane_mask;
  logic               in_range, last_beat, beat_err, aw_bad, w_hs;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    beat_bytes = ADDR_WD'(1) << size;
    size_mask  = beat_bytes - ADDR_WD'(1);
    incr_addr  = addr + beat_bytes;
    next_addr  = addr;
    case (burst)
      B_INCR:  next_addr = (addr & ~size_mask) + beat_bytes;
      B_WRAP:  next_addr = ((incr_addr - wrap_base) >= wrap_size) ? wrap_base : incr_addr;
      default: next_addr = addr;
    endcase

    lane_lo = addr[ADDRLSB-1:0];
    lane_hi = lane_lo | size_mask[ADDRLSB-1:0];
    lane_mask = '0;
    for (int i = 0; i < STRB_WD; i++)
      lane_mask[i] = (ADDRLSB'(i) >= lane_lo) && (ADDRLSB'(i) <= lane_hi);

    in_range  = (addr >> ADDRLSB) < (ADDR_WD'(1) << MEM_AW);
    last_beat = (cnt == 8'd0);
    beat_err  = !in_range || (S_AXI_WLAST != last_beat);
    w_hs      = S_AXI_WVALID && S_AXI_WREADY;

    // Unsupported size or burst shape poisons the whole burst at address time.
    aw_bound = (ADDR_WD'(S_AXI_AWLEN) + ADDR_WD'(1)) << S_AXI_AWSIZE;
    aw_bad   = (int'(S_AXI_AWSIZE) > ADDRLSB) || (S_AXI_AWBURST == 2'b11) ||
               ((S_AXI_AWBURST == B_WRAP) &&
                !(S_AXI_AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      addr          <= '0;
      wrap_base     <= '0;
      wrap_size     <= '0;
      size          <= '0;
      burst         <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      no_write      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            addr          <= S_AXI_AWADDR;
            size          <= S_AXI_AWSIZE;
            burst         <= S_AXI_AWBURST;
            cnt           <= S_AXI_AWLEN;
            wrap_size     <= aw_bound;
            wrap_base     <= S_AXI_AWADDR & ~(aw_bound - ADDR_WD'(1));
            err           <= aw_bad;
            no_write      <= aw_bad;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (!no_write && in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr[ADDRLSB +: MEM_AW];
              mem_wdata <= S_AXI_WDATA;
              mem_wstrb <= S_AXI_WSTRB & lane_mask;
            end
            addr <= next_addr;
            if (last_beat) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= (err || beat_err) ? 2'b10 : 2'b00;
              state        <= RESP;
            end else begin
              cnt <= cnt - 8'd1;
              err <= err || beat_err;
            end
          end
        end
        RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_AWREADY <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_write.sv
// Randomized bench for axi_slave_write: a closed-form burst model predicts the
// memory writes and BRESP, a negedge monitor collects what the DUT wrote.
module tb_axi_slave_write;

  logic        clk = 1'b0;
  logic        reset;
  logic        S_AXI_AWVALID;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE;
  logic [1:0]  S_AXI_AWBURST;
  logic        S_AXI_AWREADY;
  logic        S_AXI_WVALID;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WREADY;
  logic        S_AXI_BVALID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BREADY;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  axi_slave_write #(.ADDR_WD(32), .DATA_WD(32), .MEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BREADY(S_AXI_BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [31:0] beat_d[$];
  logic [3:0]  beat_s[$];
  bit          beat_l[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (mem_we) obs_q.push_back('{addr: mem_addr, data: mem_wdata, strb: mem_wstrb});

  // Byte lanes covered by a beat of nb bytes at byte address a (4-byte bus).
  function automatic logic [3:0] lanes(input logic [31:0] a, input int unsigned nb);
    int unsigned first = a % 4;
    int unsigned last  = (first + nb - 1 - (a % nb));
    logic [3:0]  m = '0;
    for (int b = 0; b < 4; b++)
      if (b >= first && b <= last) m[b] = 1'b1;
    return m;
  endfunction

  task automatic build_expected(input logic [31:0] start, input int len, input int sz,
                                input int bt, output logic [1:0] resp);
    int unsigned nb, bound;
    logic [31:0] a, base;
    bit          bad_aw, err;
    nb     = 1 << sz;
    bad_aw = (sz > 2) || (bt == 3) || (bt == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    err    = bad_aw;
    bound  = (len + 1) * nb;
    base   = start & ~(bound - 1);
    exp_q.delete();
    for (int k = 0; k <= len; k++) begin
      case (bt)
        0:       a = start;
        1:       a = (k == 0) ? start : (start & ~(nb - 1)) + k * nb;
        default: a = base + ((start - base + k * nb) % bound);
      endcase
      if ((a >> 2) >= 1024) err = 1;
      else if (!bad_aw)
        exp_q.push_back('{addr: a[11:2], data: beat_d[k], strb: beat_s[k] & lanes(a, nb)});
      if (beat_l[k] != (k == len)) err = 1;
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic send_aw(input logic [31:0] a, input int len, input int sz, input int bt);
    int n = 0;
    @(negedge clk);
    S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = a; S_AXI_AWLEN = 8'(len);
    S_AXI_AWSIZE = 3'(sz); S_AXI_AWBURST = 2'(bt);
    while (!S_AXI_AWREADY && n < 50) begin @(negedge clk); n++; end
    check("aw_ready", S_AXI_AWREADY, 1);
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    check("aw_drop", S_AXI_AWREADY, 0);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input bit l);
    int n = 0;
    S_AXI_WVALID = 1'b1; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WLAST = l;
    while (!S_AXI_WREADY && n < 50) begin @(negedge clk); n++; end
    check("w_ready", S_AXI_WREADY, 1);
    @(negedge clk);
  endtask

  task automatic do_burst(input logic [31:0] a, input int len, input int sz, input int bt,
                          input int bad, input int bdly, input bit rnd);
    logic [1:0] exp_resp;
    int         n;
    beat_d.delete(); beat_s.delete(); beat_l.delete();
    for (int k = 0; k <= len; k++) begin
      beat_d.push_back(rnd ? $urandom : 32'hA500_0000 + k);
      beat_s.push_back(rnd ? 4'($urandom) : 4'hF);
      beat_l.push_back((k == len) ^ (k == bad));
    end
    build_expected(a, len, sz, bt, exp_resp);
    obs_q.delete();
    send_aw(a, len, sz, bt);
    for (int k = 0; k <= len; k++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        S_AXI_WVALID = 1'b0;
        @(negedge clk);
      end
      send_beat(beat_d[k], beat_s[k], beat_l[k]);
    end
    S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    check("bvalid", S_AXI_BVALID, 1);
    check("bresp", S_AXI_BRESP, exp_resp);
    check("wready_in_resp", S_AXI_WREADY, 0);
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      check("bvalid_hold", S_AXI_BVALID, 1);
      check("bresp_hold", S_AXI_BRESP, exp_resp);
      check("awready_in_resp", S_AXI_AWREADY, 0);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    check("bvalid_clear", S_AXI_BVALID, 0);
    check("bresp_clear", S_AXI_BRESP, 0);
    check("awready_return", S_AXI_AWREADY, 1);
    check("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("mem_addr", obs_q[i].addr, exp_q[i].addr);
      check("mem_wdata", obs_q[i].data, exp_q[i].data);
      check("mem_wstrb", obs_q[i].strb, exp_q[i].strb);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    S_AXI_AWVALID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_AWSIZE = 0; S_AXI_AWBURST = 0;
    S_AXI_WVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WLAST = 0; S_AXI_BREADY = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_awready", S_AXI_AWREADY, 1);
    check("rst_wready", S_AXI_WREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_bresp", S_AXI_BRESP, 0);
    check("rst_mem", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 0);

    // Stray W and B traffic while idle must be ignored.
    S_AXI_WVALID = 1'b1; S_AXI_WLAST = 1'b1; S_AXI_WSTRB = 4'hF; S_AXI_BREADY = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wready", S_AXI_WREADY, 0);
    check("idle_mem_we", mem_we, 0);
    check("idle_bvalid", S_AXI_BVALID, 0);
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_BREADY = 1'b0;

    do_burst(32'h100,  3, 2, 1, -1, 0, 0);
    check("incr_first_word", obs_q.size() > 0 ? obs_q[0].addr : 10'h3FF, 10'h040);
    do_burst(32'h38,   3, 2, 2, -1, 1, 0);
    check("wrap_third_word", obs_q.size() > 2 ? obs_q[2].addr : 10'h3FF, 10'h00C);
    do_burst(32'h101,  2, 0, 1, -1, 0, 0);
    do_burst(32'h1000, 2, 2, 0, -1, 2, 0);
    do_burst(32'h80,   3, 2, 1,  1, 5, 0);
    do_burst(32'h40,   0, 2, 1, -1, 0, 0);
    do_burst(32'hFFC,  3, 2, 1, -1, 0, 0);

    // Reset in the middle of a long burst abandons it without a B response.
    send_aw(32'h200, 7, 2, 1);
    send_beat(32'h1111_1111, 4'hF, 1'b0);
    send_beat(32'h2222_2222, 4'hF, 1'b0);
    S_AXI_WVALID = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_awready", S_AXI_AWREADY, 1);
    check("midrst_wready", S_AXI_WREADY, 0);
    check("midrst_bvalid", S_AXI_BVALID, 0);
    @(negedge clk);
    check("midrst_bvalid_later", S_AXI_BVALID, 0);
    do_burst(32'h200, 7, 2, 1, -1, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int          len, sz, bt, bad;
      logic [31:0] a;
      bt  = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
      sz  = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
      len = (bt == 2 && $urandom_range(0, 3) != 0) ? (2 << $urandom_range(0, 3)) - 1
                                                   : $urandom_range(0, 15);
      a   = $urandom_range(0, 32'h10FF);
      if (bt == 2) a = a & ~((32'd1 << sz) - 1);
      bad = $urandom_range(0, 7) == 0 ? $urandom_range(0, len) : -1;
      do_burst(a, len, sz, bt, bad, $urandom_range(0, 3), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
